// File: rtl/instr_fetch_unit.sv
// RISC-V fetch front end: PC register, req/ack instruction fetch, next-PC select,
// and sticky misalign/timeout error detection with a terminal ERROR state.
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      PCsrc,
  input  logic [XLEN-1:0] immext,
  input  logic [XLEN-1:0] ALUresult,
  input  logic            exec_done,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCplus4,
  output logic            misalign_err,
  output logic            fetch_err
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_ERROR} state_t;

  localparam int CW = $clog2(TIMEOUT) + 1;

  state_t          state;
  logic [CW-1:0]   tmo_cnt;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] jalr_tgt;

  assign PCplus4     = PC + XLEN'(4);
  assign jalr_tgt    = ALUresult & ~XLEN'(1);
  assign imem_req    = (state == S_FETCH);
  assign imem_addr   = PC;
  assign instr_valid = (state == S_EXEC);

  always_comb begin
    next_pc = PCplus4;
    if (PCsrc[1])      next_pc = jalr_tgt;
    else if (PCsrc[0]) next_pc = PC + immext;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      PC           <= RESET_PC;
      instr        <= '0;
      tmo_cnt      <= '0;
      misalign_err <= 1'b0;
      fetch_err    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          // ack in the last allowed cycle still wins over the timeout
          if (imem_ack) begin
            instr   <= imem_rdata;
            tmo_cnt <= '0;
            state   <= S_EXEC;
          end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
            fetch_err <= 1'b1;
            state     <= S_ERROR;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        S_EXEC: begin
          if (exec_done) begin
            // PC takes the target even when misaligned so the fault address is visible
            PC <= next_pc;
            if (next_pc[1:0] != 2'b00) begin
              misalign_err <= 1'b1;
              state        <= S_ERROR;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_ERROR: state <= S_ERROR;
        default: state <= S_ERROR;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized self-checking bench for instr_fetch_unit against a transaction-level
// model: expected PC, next-PC arithmetic and a synthetic instruction memory.
module tb_instr_fetch_unit;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  PCsrc;
  logic [31:0] immext, ALUresult;
  logic        exec_done;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] PC, PCplus4;
  logic        misalign_err, fetch_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] pc;
  bit          in_err;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .PCsrc(PCsrc), .immext(immext), .ALUresult(ALUresult),
    .exec_done(exec_done), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .PC(PC), .PCplus4(PCplus4),
    .misalign_err(misalign_err), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // reset for 3 cycles, check reset state, then advance into FETCH
  task automatic do_reset();
    rst_n = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    pc = 32'h0; in_err = 1'b0;
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_pc", PC, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_flags", {29'b0, instr_valid, misalign_err, fetch_err}, 32'h0);
    step();
    chk("first_req", {31'b0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);
  endtask

  // serve one fetch after 'dly' idle cycles; spurious exec_done must be ignored
  task automatic do_fetch(input int dly);
    logic [31:0] w;
    chk("fetch_addr", imem_addr, pc);
    for (int i = 0; i < dly; i++) begin
      imem_ack = 1'b0; imem_rdata = $urandom; exec_done = 1'($urandom_range(0, 1));
      step();
      chk("fetch_wait_req", {31'b0, imem_req, instr_valid}, 32'h2);
    end
    w = mem_word(pc);
    imem_ack = 1'b1; imem_rdata = w; exec_done = 1'($urandom_range(0, 1));
    step();
    imem_ack = 1'b0; exec_done = 1'b0;
    chk("ack_valid", {30'b0, imem_req, instr_valid}, 32'h1);
    chk("ack_instr", instr, w);
  endtask

  // hold EXEC for 'dly' cycles with stray acks, then retire with the given next-PC inputs
  task automatic do_exec(input int dly, input logic [1:0] src, input logic [31:0] imm,
                         input logic [31:0] alu);
    logic [31:0] w, nxt;
    w = instr;
    for (int i = 0; i < dly; i++) begin
      imem_ack = 1'b1; imem_rdata = $urandom; exec_done = 1'b0;
      step();
      chk("exec_hold", instr, w);
      chk("exec_valid", {31'b0, instr_valid}, 32'h1);
    end
    chk("pcplus4", PCplus4, pc + 32'd4);
    imem_ack = 1'b0;
    PCsrc = src; immext = imm; ALUresult = alu; exec_done = 1'b1;
    case (src)
      2'b00:   nxt = pc + 32'd4;
      2'b01:   nxt = pc + imm;
      default: nxt = {alu[31:1], 1'b0};
    endcase
    step();
    exec_done = 1'b0;
    pc = nxt;
    chk("next_pc", PC, nxt);
    if (nxt[1:0] != 2'b00) begin
      in_err = 1'b1;
      chk("misalign", {29'b0, misalign_err, imem_req, instr_valid}, 32'h4);
    end else begin
      chk("next_fetch", {30'b0, imem_req, misalign_err}, 32'h2);
      chk("next_addr", imem_addr, nxt);
    end
  endtask

  // ERROR must be terminal regardless of ack/exec_done activity
  task automatic check_error_hold(input logic [31:0] flags);
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b1; imem_rdata = $urandom; exec_done = 1'b1;
      PCsrc = 2'($urandom); immext = $urandom; ALUresult = $urandom;
      step();
      chk("err_hold_flags", {28'b0, misalign_err, fetch_err, imem_req, instr_valid}, flags);
      chk("err_hold_pc", PC, pc);
    end
    imem_ack = 1'b0; exec_done = 1'b0;
  endtask

  initial begin
    logic [1:0]  src;
    logic [31:0] imm, alu;
    rst_n = 1'b0; PCsrc = 2'b00; immext = '0; ALUresult = '0;
    exec_done = 1'b0; imem_ack = 1'b0; imem_rdata = '0;

    // T1/T2: reset and sequential fetches with 3-cycle ack delay
    do_reset();
    for (int i = 0; i < 3; i++) begin
      do_fetch(3);
      do_exec(1, 2'b00, 32'h0, 32'h0);
    end
    chk("t2_addr", imem_addr, 32'hC);

    // T3: branch back and jalr with bit 0 cleared
    do_reset();
    do_fetch(0); do_exec(0, 2'b01, 32'h10, 32'h0);
    do_fetch(1); do_exec(0, 2'b01, 32'hFFFF_FFF8, 32'h0);
    chk("t3_branch", imem_addr, 32'h8);
    do_fetch(0); do_exec(2, 2'b10, 32'h0, 32'h201);
    chk("t3_jalr", imem_addr, 32'h200);

    // T4: misaligned branch target goes to ERROR with PC=0x6
    do_reset();
    do_fetch(0); do_exec(0, 2'b01, 32'h6, 32'h0);
    chk("t4_pc", PC, 32'h6);
    check_error_hold(32'h8);

    // T5: timeout after the 16th FETCH cycle; ack in cycle 15 or 16 avoids it
    do_reset();
    for (int i = 0; i < TMO - 1; i++) step();
    chk("t5_no_err_yet", {30'b0, fetch_err, imem_req}, 32'h1);
    step();
    chk("t5_timeout", {30'b0, fetch_err, imem_req}, 32'h2);
    check_error_hold(32'h4);
    for (int last = TMO - 1; last <= TMO; last++) begin
      do_reset();
      do_fetch(last - 1);
      chk("t5_ack_late", {30'b0, fetch_err, instr_valid}, 32'h1);
    end

    // T6: reset while waiting at PC=0x40; ack during reset is ignored
    do_reset();
    do_fetch(0); do_exec(0, 2'b01, 32'h40, 32'h0);
    step(); step();
    rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step(); step();
    chk("t6_pc", PC, 32'h0);
    chk("t6_instr", instr, 32'h0);
    chk("t6_flags", {30'b0, imem_req, instr_valid}, 32'h0);
    rst_n = 1'b1; imem_ack = 1'b0; pc = 32'h0;
    step();
    chk("t6_refetch", {imem_addr[30:0], imem_req}, 32'h1);
    do_fetch(2);

    // randomized instruction stream
    do_reset();
    for (int t = 0; t < 150; t++) begin
      if (in_err) begin
        check_error_hold(32'h8);
        do_reset();
      end
      do_fetch($urandom_range(0, 5));
      src = 2'($urandom_range(0, 3));
      imm = 32'($signed($urandom_range(0, 64)) - 32) <<< 2;
      if ($urandom_range(0, 7) == 0) imm = imm | 32'($urandom_range(1, 3));
      alu = $urandom;
      if ($urandom_range(0, 7) != 0) alu[1] = 1'b0;
      do_exec($urandom_range(0, 3), src, imm, alu);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
